ex_unit: RTL and testbench

Execute stage of the 5-stage LoongArch pipeline. It sits between ID and ME and uses the same valid/allow-in handshake as its neighbours. It computes ALU, multiply and iterative divide results, issues data SRAM requests, and raises the address-misalign exception. It packs EX_to_ME_Bus in the exact field order the ME stage unpacks.

---
 rtl/ex_unit_pkg.sv | 60 ++++++
 rtl/ex_unit_div.sv | 80 ++++++++
 rtl/ex_unit.sv | 153 +++++++++++++++
 tb/tb_ex_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_unit_pkg.sv
// Shared types and constants for the execute stage: bus layouts toward ID/ME,
// memory-size encoding, exception codes and the divider state encoding.
package ex_unit_pkg;

    localparam int ID_TO_EX_BUS_SIZE = 214;
    localparam int EX_TO_ME_BUS_SIZE = 131;

    localparam logic [5:0] ECODE_ALE = 6'h09;

    localparam logic [1:0] MSIZE_B = 2'b00;
    localparam logic [1:0] MSIZE_H = 2'b01;
    localparam logic [1:0] MSIZE_W = 2'b10;

    // alu_op bits: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 nor, 7 xor,
    //              8 sll, 9 srl, 10 sra, 11 lui (src2 already holds imm<<12)
    // md_op bits:  0 mul.w, 1 mulh.w, 2 mulhu.w, 3 div.w, 4 mod.w, 5 div.wu, 6 mod.wu
    typedef struct packed {
        logic        excp_en;
        logic [5:0]  excp_num;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic        inst_ertn;
        logic [11:0] alu_op;
        logic [6:0]  md_op;
        logic        mem_en;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic        mem_sign;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic [31:0] pc;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } id_ex_bus_t;

    typedef struct packed {
        logic        excp_en;
        logic [5:0]  excp_num;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic        inst_ertn;
        logic [4:0]  dest_flag;
        logic [31:0] pc;
        logic [31:0] ex_result;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } ex_me_bus_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_unit_div.sv
// Iterative restoring divider: one quotient bit per cycle over magnitudes,
// sign fixup and divide-by-zero override applied on the held result.
module ex_div
    import ex_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         start,
    input  logic         is_signed,
    input  logic         is_mod,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         take,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CW = $clog2(W);

    div_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo, rem, dsr, dvd;
    logic          neg_q, neg_r, by_zero, mod_sel;
    logic [W:0]    diff;
    logic          step_bit;
    logic [W-1:0]  quo_fix, rem_fix;

    // State register; a flush abandons any division in flight
    always_ff @(posedge clk) begin
        if (reset || flush) state <= DIV_IDLE;
        else                state <= state_nxt;
    end

    // Next state: IDLE -> CALC for W steps -> DONE until ME takes the result
    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_IDLE: if (start) state_nxt = DIV_CALC;
            DIV_CALC: if (cnt == CW'(W - 1)) state_nxt = DIV_DONE;
            DIV_DONE: if (take) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Outputs: result is valid only while parked in DONE
    always_comb begin
        done = (state == DIV_DONE);
    end

    // Datapath: latch magnitudes on start, then shift/subtract once per CALC cycle
    always_ff @(posedge clk) begin
        if (state == DIV_IDLE && start) begin
            quo     <= (is_signed && dividend[W-1]) ? -dividend : dividend;
            dsr     <= (is_signed && divisor[W-1])  ? -divisor  : divisor;
            rem     <= '0;
            cnt     <= '0;
            dvd     <= dividend;
            neg_q   <= is_signed && (dividend[W-1] ^ divisor[W-1]);
            neg_r   <= is_signed && dividend[W-1];
            by_zero <= (divisor == '0);
            mod_sel <= is_mod;
        end else if (state == DIV_CALC) begin
            rem <= step_bit ? diff[W-1:0] : {rem[W-2:0], quo[W-1]};
            quo <= {quo[W-2:0], step_bit};
            cnt <= cnt + 1'b1;
        end
    end

    // Trial subtraction; a clear borrow bit means the divisor fits
    assign diff     = {rem, quo[W-1]} - {1'b0, dsr};
    assign step_bit = ~diff[W];

    assign quo_fix = neg_q ? -quo : quo;
    assign rem_fix = neg_r ? -rem : rem;
    assign result  = by_zero ? (mod_sel ? dvd : {W{1'b1}})
                             : (mod_sel ? rem_fix : quo_fix);

endmodule

// File: rtl/ex_unit.sv
// Execute stage: ALU, multiplier, iterative divider, data SRAM request and
// misaligned-access exception, with valid/allow-in handshake to ID and ME.
module ex_unit
    import ex_unit_pkg::*;
#(
    parameter int         DIV_W    = 32,
    parameter logic [5:0] EXCP_ALE = ECODE_ALE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ID_to_EX_Valid,
    input  logic [ID_TO_EX_BUS_SIZE-1:0] ID_to_EX_Bus,
    output logic                         EX_Allow_in,
    input  logic                         ME_Allow_in,
    output logic                         EX_to_ME_Valid,
    output logic [EX_TO_ME_BUS_SIZE-1:0] EX_to_ME_Bus,
    output logic [4:0]                   EX_dest,
    output logic [31:0]                  EX_Forward_Res,
    output logic                         EX_Load_op,
    input  logic                         ME_Sys_op,
    input  logic                         excp_flush,
    input  logic                         ertn_flush,
    output logic                         data_sram_en,
    output logic [3:0]                   data_sram_we,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata
);
    id_ex_bus_t        bus;
    ex_me_bus_t        obus;
    logic              ex_valid, ready_go, flush;
    logic              is_mul, is_div, div_done;
    logic [31:0]       div_res, alu_res, mul_res, ex_result;
    logic [31:0]       add_res, addr;
    logic [4:0]        sa;
    logic signed [32:0] ma, mb;
    logic signed [63:0] prod;
    logic              ale, final_excp, is_load;
    logic [4:0]        dest_flag;
    logic [3:0]        strobe;
    logic              req;

    assign flush = excp_flush | ertn_flush;

    // Stage valid: cleared by flush, otherwise follows ID whenever we accept
    always_ff @(posedge clk) begin
        if (reset || flush)   ex_valid <= 1'b0;
        else if (EX_Allow_in) ex_valid <= ID_to_EX_Valid;
    end

    // Instruction fields captured on an accepted handoff
    always_ff @(posedge clk) begin
        if (reset)                              bus <= '0;
        else if (ID_to_EX_Valid && EX_Allow_in) bus <= id_ex_bus_t'(ID_to_EX_Bus);
    end

    assign is_mul         = |bus.md_op[2:0];
    assign is_div         = |bus.md_op[6:3];
    assign ready_go       = !is_div || div_done;
    assign EX_Allow_in    = !ex_valid || (ready_go && ME_Allow_in);
    assign EX_to_ME_Valid = ex_valid && ready_go;

    assign add_res = bus.src1 + bus.src2;
    assign sa      = bus.src2[4:0];

    // One-hot ALU select; each op contributes only when its bit is set
    always_comb begin
        alu_res = '0;
        if (bus.alu_op[0])  alu_res |= add_res;
        if (bus.alu_op[1])  alu_res |= bus.src1 - bus.src2;
        if (bus.alu_op[2])  alu_res |= {31'b0, $signed(bus.src1) < $signed(bus.src2)};
        if (bus.alu_op[3])  alu_res |= {31'b0, bus.src1 < bus.src2};
        if (bus.alu_op[4])  alu_res |= bus.src1 & bus.src2;
        if (bus.alu_op[5])  alu_res |= bus.src1 | bus.src2;
        if (bus.alu_op[6])  alu_res |= ~(bus.src1 | bus.src2);
        if (bus.alu_op[7])  alu_res |= bus.src1 ^ bus.src2;
        if (bus.alu_op[8])  alu_res |= bus.src1 << sa;
        if (bus.alu_op[9])  alu_res |= bus.src1 >> sa;
        if (bus.alu_op[10]) alu_res |= $signed(bus.src1) >>> sa;
        if (bus.alu_op[11]) alu_res |= bus.src2;
    end

    // 33x33 signed multiply; mulhu zero-extends so one multiplier serves all three
    assign ma      = {bus.md_op[2] ? 1'b0 : bus.src1[31], bus.src1};
    assign mb      = {bus.md_op[2] ? 1'b0 : bus.src2[31], bus.src2};
    assign prod    = ma * mb;
    assign mul_res = bus.md_op[0] ? prod[31:0] : prod[63:32];

    ex_div #(.W(DIV_W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (ex_valid && is_div && !flush),
        .is_signed (bus.md_op[3] | bus.md_op[4]),
        .is_mod    (bus.md_op[4] | bus.md_op[6]),
        .dividend  (bus.src1),
        .divisor   (bus.src2),
        .take      (EX_to_ME_Valid && ME_Allow_in),
        .done      (div_done),
        .result    (div_res)
    );

    assign ex_result = is_div ? div_res : (is_mul ? mul_res : alu_res);

    // Memory access: alignment check, load extension flags, store lanes
    assign addr       = add_res;
    assign ale        = bus.mem_en && (((bus.mem_size == MSIZE_H) && addr[0]) ||
                                       ((bus.mem_size == MSIZE_W) && (addr[1:0] != 2'b00)));
    assign final_excp = bus.excp_en || ale;
    assign is_load    = bus.mem_en && !bus.mem_we;
    assign dest_flag  = (is_load && bus.mem_size != MSIZE_W)
                      ? {bus.mem_sign, bus.mem_size == MSIZE_B, bus.mem_size == MSIZE_H, addr[1:0]}
                      : 5'b00000;

    // Byte strobes by access size and offset
    always_comb begin
        strobe = 4'hF;
        if (bus.mem_size == MSIZE_B)      strobe = 4'b0001 << addr[1:0];
        else if (bus.mem_size == MSIZE_H) strobe = addr[1] ? 4'b1100 : 4'b0011;
    end

    // Request fires once, on the cycle the instruction hands off to ME
    assign req = ex_valid && bus.mem_en && !final_excp && !ME_Sys_op && !flush &&
                 ready_go && ME_Allow_in;

    assign data_sram_en    = req;
    assign data_sram_we    = (req && bus.mem_we) ? strobe : 4'b0000;
    assign data_sram_addr  = {addr[31:2], 2'b00};
    assign data_sram_wdata = (bus.mem_size == MSIZE_B) ? {4{bus.rkd_value[7:0]}}  :
                             (bus.mem_size == MSIZE_H) ? {2{bus.rkd_value[15:0]}} :
                                                         bus.rkd_value;

    // Outgoing bus; an upstream exception keeps its own code
    always_comb begin
        obus.excp_en      = final_excp;
        obus.excp_num     = bus.excp_en ? bus.excp_num : (ale ? EXCP_ALE : bus.excp_num);
        obus.csr_num      = bus.csr_num;
        obus.csr_we       = bus.csr_we;
        obus.csr_wvalue   = bus.csr_wvalue;
        obus.inst_ertn    = bus.inst_ertn;
        obus.dest_flag    = dest_flag;
        obus.pc           = bus.pc;
        obus.ex_result    = ex_result;
        obus.res_from_mem = bus.res_from_mem;
        obus.gr_we        = bus.gr_we;
        obus.dest         = bus.dest;
    end

    assign EX_to_ME_Bus   = obus;
    assign EX_dest        = (ex_valid && bus.gr_we) ? bus.dest : 5'd0;
    assign EX_Forward_Res = {32{bus.gr_we}} & ex_result;
    assign EX_Load_op     = ex_valid && bus.res_from_mem;

endmodule

// File: tb/tb_ex_unit.sv
// Bench for ex_unit: directed corner cases plus random ALU/mul/div/memory
// instructions checked against an arithmetic reference model.
module tb_ex_unit;
    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid;
    logic [213:0] id_bus;
    logic         ex_allow;
    logic         me_allow;
    logic         ex_me_valid;
    logic [130:0] ex_me_bus;
    logic [4:0]   ex_dest;
    logic [31:0]  ex_fwd;
    logic         ex_load;
    logic         me_sys;
    logic         excp_flush, ertn_flush;
    logic         sram_en;
    logic [3:0]   sram_we;
    logic [31:0]  sram_addr, sram_wdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_EX_Valid  (id_valid),
        .ID_to_EX_Bus    (id_bus),
        .EX_Allow_in     (ex_allow),
        .ME_Allow_in     (me_allow),
        .EX_to_ME_Valid  (ex_me_valid),
        .EX_to_ME_Bus    (ex_me_bus),
        .EX_dest         (ex_dest),
        .EX_Forward_Res  (ex_fwd),
        .EX_Load_op      (ex_load),
        .ME_Sys_op       (me_sys),
        .excp_flush      (excp_flush),
        .ertn_flush      (ertn_flush),
        .data_sram_en    (sram_en),
        .data_sram_we    (sram_we),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ID_to_EX bus in the field order ID packs it
    function automatic logic [213:0] mk(input logic ee, input logic [5:0] en,
                                        input logic [11:0] alu, input logic [6:0] md,
                                        input logic me, input logic mw, input logic [1:0] msz,
                                        input logic ms, input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] rkd, input logic [31:0] pc,
                                        input logic rfm, input logic gw, input logic [4:0] dst);
        return {ee, en, 14'h0123, 1'b0, 32'hC5C5_0000, 1'b0, alu, md, me, mw, msz, ms,
                s1, s2, rkd, pc, rfm, gw, dst};
    endfunction

    function automatic logic [31:0] alu_ref(input int k, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return a | b;
            6:  return ~(a | b);
            7:  return a ^ b;
            8:  return a << s;
            9:  return a >> s;
            10: return $signed(a) >>> s;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] mul_ref(input int k, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        logic [63:0] up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'h0, a} * {32'h0, b};
        if (k == 0) return sp[31:0];
        if (k == 1) return sp[63:32];
        return up[63:32];
    endfunction

    // k: 0 div.w, 1 mod.w, 2 div.wu, 3 mod.wu
    function automatic logic [31:0] div_ref(input int k, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, t;
        if (b == 32'd0) return (k == 1 || k == 3) ? a : 32'hFFFF_FFFF;
        if (k < 2) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            t  = (k == 0) ? sa / sb : sa % sb;
            return t[31:0];
        end
        return (k == 2) ? a / b : a % b;
    endfunction

    task automatic issue(input logic [213:0] b);
        @(negedge clk);
        id_valid = 1'b1;
        id_bus   = b;
        @(negedge clk);
        id_valid = 1'b0;
        #1;
    endtask

    task automatic run_div(input string tag, input int k, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [6:0] md;
        md = 7'b0000001 << (3 + k);
        issue(mk(1'b0, 6'h0, 12'h000, md, 1'b0, 1'b0, 2'b00, 1'b0, a, b, 32'h0, 32'h1C00_0100,
                 1'b0, 1'b1, 5'd9));
        check({tag, "_allow"}, {31'b0, ex_allow}, 32'd0);
        n = 0;
        while (ex_me_valid !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_lat"}, n, 32'd33);
        check({tag, "_res"}, ex_me_bus[38:7], div_ref(k, a, b));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          k, sz, nb, off;
        logic        st, sg, misal;
        logic [31:0] a, b, base, s2, ad, rkd, wd, r;
        logic [3:0]  we;
        logic [11:0] alu;
        logic [11:0] one12;
        logic [6:0]  md;
        logic [6:0]  one7;
        logic [4:0]  fl;

        one12 = 12'h001;
        one7  = 7'h01;
        reset = 1'b1; id_valid = 1'b0; id_bus = '0; me_allow = 1'b1;
        me_sys = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_valid", {31'b0, ex_me_valid}, 32'd0);
        check("rst_allow", {31'b0, ex_allow}, 32'd1);
        check("rst_en",    {31'b0, sram_en}, 32'd0);
        check("rst_we",    {28'b0, sram_we}, 32'd0);
        check("rst_dest",  {27'b0, ex_dest}, 32'd0);
        check("rst_done",  {31'b0, dut.u_div.done}, 32'd0);

        // add 5 + -7
        issue(mk(1'b0, 6'h0, 12'h001, 7'h0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd5, 32'hFFFF_FFF9, 32'h0,
                 32'h1C00_0000, 1'b0, 1'b1, 5'd3));
        check("add_valid", {31'b0, ex_me_valid}, 32'd1);
        check("add_res",   ex_me_bus[38:7], 32'hFFFF_FFFE);
        check("add_fwd",   ex_fwd, 32'hFFFF_FFFE);
        check("add_dest",  {27'b0, ex_dest}, 32'd3);
        check("add_pc",    ex_me_bus[70:39], 32'h1C00_0000);

        // divider corners
        run_div("divw",  0, 32'hFFFF_FFF9, 32'd2);
        run_div("modw",  1, 32'hFFFF_FFF9, 32'd2);
        run_div("divwu", 2, 32'd9, 32'd0);
        run_div("modwu", 3, 32'd9, 32'd0);
        run_div("divw0", 0, 32'hFFFF_FFF9, 32'd0);

        // st.h to 0x1002
        issue(mk(1'b0, 6'h0, 12'h001, 7'h0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h1000, 32'd2, 32'h1234_ABCD,
                 32'h1C00_0200, 1'b0, 1'b0, 5'd0));
        check("sth_en",    {31'b0, sram_en}, 32'd1);
        check("sth_we",    {28'b0, sram_we}, 32'hC);
        check("sth_wdata", sram_wdata, 32'hABCD_ABCD);
        check("sth_addr",  sram_addr, 32'h1000);
        me_allow = 1'b0;
        #1;
        check("sth_stall_en",    {31'b0, sram_en}, 32'd0);
        check("sth_stall_allow", {31'b0, ex_allow}, 32'd0);
        me_allow = 1'b1;
        #1;
        check("sth_resume_en", {31'b0, sram_en}, 32'd1);

        // same store while ME holds a system op
        me_sys = 1'b1;
        issue(mk(1'b0, 6'h0, 12'h001, 7'h0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h1000, 32'd2, 32'h1234_ABCD,
                 32'h1C00_0204, 1'b0, 1'b0, 5'd0));
        check("sth_sys_en", {31'b0, sram_en}, 32'd0);
        me_sys = 1'b0;

        // ld.w misaligned
        issue(mk(1'b0, 6'h0, 12'h001, 7'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'd1, 32'h0,
                 32'h1C00_0208, 1'b1, 1'b1, 5'd4));
        check("ldw_excp", {31'b0, ex_me_bus[130]}, 32'd1);
        check("ldw_num",  {26'b0, ex_me_bus[129:124]}, 32'h09);
        check("ldw_en",   {31'b0, sram_en}, 32'd0);

        // upstream exception keeps its code even when misaligned
        issue(mk(1'b1, 6'h0A, 12'h001, 7'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'd1, 32'h0,
                 32'h1C00_020C, 1'b1, 1'b1, 5'd4));
        check("up_num", {26'b0, ex_me_bus[129:124]}, 32'h0A);
        check("up_en",  {31'b0, sram_en}, 32'd0);

        // ld.b signed at 0x1003
        issue(mk(1'b0, 6'h0, 12'h001, 7'h0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h1000, 32'd3, 32'h0,
                 32'h1C00_0210, 1'b1, 1'b1, 5'd6));
        check("ldb_flag", {27'b0, ex_me_bus[75:71]}, 32'h1B);
        check("ldb_en",   {31'b0, sram_en}, 32'd1);
        check("ldb_we",   {28'b0, sram_we}, 32'd0);
        check("ldb_load", {31'b0, ex_load}, 32'd1);

        // flush during CALC cycle 10
        issue(mk(1'b0, 6'h0, 12'h000, 7'h08, 1'b0, 1'b0, 2'b00, 1'b0, 32'd1000, 32'd3, 32'h0,
                 32'h1C00_0300, 1'b0, 1'b1, 5'd7));
        repeat (11) @(negedge clk);
        excp_flush = 1'b1;
        @(negedge clk);
        excp_flush = 1'b0;
        #1;
        check("flush_valid", {31'b0, ex_me_valid}, 32'd0);
        check("flush_allow", {31'b0, ex_allow}, 32'd1);
        check("flush_done",  {31'b0, dut.u_div.done}, 32'd0);
        check("flush_dest",  {27'b0, ex_dest}, 32'd0);
        run_div("post_flush", 0, 32'd100, 32'd7);

        // random ALU
        for (int i = 0; i < 30; i++) begin
            k   = $urandom_range(0, 11);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            alu = one12 << k;
            issue(mk(1'b0, 6'h0, alu, 7'h0, 1'b0, 1'b0, 2'b00, 1'b0, a, b, 32'h0, 32'h1C00_1000,
                     1'b0, 1'b1, 5'd1));
            check($sformatf("alu%0d", k), ex_me_bus[38:7], alu_ref(k, a, b));
        end

        // random multiply
        for (int i = 0; i < 12; i++) begin
            k  = $urandom_range(0, 2);
            a  = $urandom;
            b  = $urandom;
            md = one7 << k;
            issue(mk(1'b0, 6'h0, 12'h000, md, 1'b0, 1'b0, 2'b00, 1'b0, a, b, 32'h0, 32'h1C00_2000,
                     1'b0, 1'b1, 5'd2));
            check($sformatf("mul%0d", k), ex_me_bus[38:7], mul_ref(k, a, b));
        end

        // random divide
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 3);
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            run_div($sformatf("rdiv%0d", k), k, a, b);
        end

        // random loads/stores
        for (int i = 0; i < 24; i++) begin
            sz    = $urandom_range(0, 2);
            nb    = 1 << sz;
            st    = 1'($urandom_range(0, 1));
            sg    = st ? 1'b0 : 1'($urandom_range(0, 1));
            base  = $urandom & 32'hFFFF_FFF0;
            s2    = 32'($urandom_range(0, 15));
            ad    = base + s2;
            off   = int'(ad[1:0]);
            misal = (off % nb) != 0;
            rkd   = $urandom;
            issue(mk(1'b0, 6'h0, 12'h001, 7'h0, 1'b1, st, 2'(sz), sg, base, s2, rkd, 32'h1C00_3000,
                     !st, !st, 5'd5));
            check("mem_en",   {31'b0, sram_en}, {31'b0, !misal});
            check("mem_excp", {31'b0, ex_me_bus[130]}, {31'b0, misal});
            check("mem_addr", sram_addr, ad & 32'hFFFF_FFFC);
            check("mem_res",  ex_me_bus[38:7], ad);
            if (st) begin
                we = 4'b0000;
                wd = 32'h0;
                for (int j = 0; j < 4; j++) begin
                    if (j >= off && j < off + nb) we[j] = 1'b1;
                    wd[8*j +: 8] = rkd[8*(j % nb) +: 8];
                end
                if (!misal) check("st_we", {28'b0, sram_we}, {28'b0, we});
                check("st_wdata", sram_wdata, wd);
                check("st_flag",  {27'b0, ex_me_bus[75:71]}, 32'd0);
            end else begin
                fl = (nb < 4) ? {sg, nb == 1, nb == 2, ad[1:0]} : 5'b00000;
                check("ld_we",   {28'b0, sram_we}, 32'd0);
                check("ld_flag", {27'b0, ex_me_bus[75:71]}, {27'b0, fl});
            end
            if (misal) begin
                r = {26'b0, ex_me_bus[129:124]};
                check("mem_num", r, 32'h09);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
